ntp_time_select: RTL and testbench



---
 rtl/ntps_pkg.sv | 24 ++
 rtl/ntp_src_watchdog.sv | 33 +++
 rtl/ntp_time_select.sv | 130 +++++++++++++
 tb/tb_ntp_time_select.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntps_pkg.sv
// ntps_pkg: shared types and constants for the NTP time-source selector.
`default_nettype none

package ntps_pkg;

  localparam int NTP_TIME_W = 64;
  localparam int CNT_W      = 16;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_A    = 2'd1,
    SEL_B    = 2'd2
  } sel_state_t;

  function automatic sel_state_t src_state(input logic src);
    return (src == SRC_B) ? SEL_B : SEL_A;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ntp_src_watchdog.sv
// ntp_src_watchdog: declares a time source healthy while locked and still strobing.
`default_nettype none

module ntp_src_watchdog #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic upd,
  input  logic sync_ok,
  output logic healthy
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] wd;

  // Starts saturated so a source is stale until its first strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd <= LIMIT;
    end else if (upd) begin
      wd <= '0;
    end else if (wd != LIMIT) begin
      wd <= wd + 16'd1;
    end
  end

  assign healthy = sync_ok && (wd < LIMIT);

endmodule

`default_nettype wire

// File: rtl/ntp_time_select.sv
// ntp_time_select: picks a healthy NTP source (A/B) with failover, timed revert,
// manual force and a monotonic guard on the forwarded time.
`default_nettype none

module ntp_time_select
  import ntps_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int HOLDOFF_CYCLES = 10000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NTP_TIME_W-1:0] time_a,
  input  logic                  upd_a,
  input  logic                  sync_ok_a,
  input  logic [NTP_TIME_W-1:0] time_b,
  input  logic                  upd_b,
  input  logic                  sync_ok_b,
  input  logic                  pref_b,
  input  logic                  force_en,
  input  logic                  force_sel,
  output logic [NTP_TIME_W-1:0] ntp_time,
  output logic                  ntp_time_upd,
  output logic                  active_src,
  output logic                  valid,
  output logic [CNT_W-1:0]      switch_count,
  output logic [CNT_W-1:0]      drop_count
);

  localparam int              HOLD_W    = 24;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  sel_state_t              state;
  sel_state_t              state_nxt;
  logic [HOLD_W-1:0]       hold_cnt;
  logic [HOLD_W-1:0]       hold_nxt;
  logic                    healthy_a;
  logic                    healthy_b;
  logic                    pref_healthy;
  logic                    other_healthy;
  logic                    is_swap;
  logic                    fwd;
  logic [NTP_TIME_W-1:0]   cand;

  ntp_src_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd_a (
    .clk     (clk),
    .reset   (reset),
    .upd     (upd_a),
    .sync_ok (sync_ok_a),
    .healthy (healthy_a)
  );

  ntp_src_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd_b (
    .clk     (clk),
    .reset   (reset),
    .upd     (upd_b),
    .sync_ok (sync_ok_b),
    .healthy (healthy_b)
  );

  assign pref_healthy  = pref_b ? healthy_b : healthy_a;
  assign other_healthy = pref_b ? healthy_a : healthy_b;

  // Failover outranks revert; hold-off only accumulates while parked on the
  // non-preferred source with the preferred one healthy, and clears otherwise.
  always_comb begin
    state_nxt = state;
    hold_nxt  = '0;
    if (force_en) begin
      if (force_sel == SRC_B) state_nxt = healthy_b ? SEL_B : SEL_NONE;
      else                    state_nxt = healthy_a ? SEL_A : SEL_NONE;
    end else begin
      case (state)
        SEL_A: begin
          if (!healthy_a) begin
            state_nxt = healthy_b ? SEL_B : SEL_NONE;
          end else if (pref_b && healthy_b) begin
            if (hold_cnt == HOLD_LAST) state_nxt = SEL_B;
            else                       hold_nxt  = hold_cnt + 24'd1;
          end
        end
        SEL_B: begin
          if (!healthy_b) begin
            state_nxt = healthy_a ? SEL_A : SEL_NONE;
          end else if (!pref_b && healthy_a) begin
            if (hold_cnt == HOLD_LAST) state_nxt = SEL_A;
            else                       hold_nxt  = hold_cnt + 24'd1;
          end
        end
        default: begin
          if (pref_healthy)       state_nxt = src_state(pref_b);
          else if (other_healthy) state_nxt = src_state(!pref_b);
        end
      endcase
    end
  end

  assign is_swap = ((state == SEL_A) && (state_nxt == SEL_B)) ||
                   ((state == SEL_B) && (state_nxt == SEL_A));

  // Strobes are judged against the state registered in the strobe cycle.
  assign fwd  = ((state == SEL_A) && upd_a) || ((state == SEL_B) && upd_b);
  assign cand = (state == SEL_B) ? time_b : time_a;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= SEL_NONE;
      hold_cnt     <= '0;
      valid        <= 1'b0;
      active_src   <= SRC_A;
      switch_count <= '0;
      drop_count   <= '0;
      ntp_time     <= '0;
      ntp_time_upd <= 1'b0;
    end else begin
      state        <= state_nxt;
      hold_cnt     <= hold_nxt;
      valid        <= (state_nxt != SEL_NONE);
      active_src   <= (state_nxt == SEL_B);
      if (is_swap && (switch_count != CNT_MAX)) switch_count <= switch_count + 16'd1;
      ntp_time_upd <= fwd && (cand >= ntp_time);
      if (fwd && (cand >= ntp_time)) ntp_time <= cand;
      if (fwd && (cand < ntp_time) && (drop_count != CNT_MAX)) drop_count <= drop_count + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ntp_time_select.sv
// tb_ntp_time_select: randomized self-checking bench with an event-level reference model.
`default_nettype none

module tb_ntp_time_select;

  localparam int TO = 20;
  localparam int HO = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] time_a, time_b;
  logic        upd_a, upd_b, sync_ok_a, sync_ok_b, pref_b, force_en, force_sel;
  logic [63:0] ntp_time;
  logic        ntp_time_upd, active_src, valid;
  logic [15:0] switch_count, drop_count;

  ntp_time_select #(.TIMEOUT_CYCLES(TO), .HOLDOFF_CYCLES(HO)) dut (
    .clk(clk), .reset(reset),
    .time_a(time_a), .upd_a(upd_a), .sync_ok_a(sync_ok_a),
    .time_b(time_b), .upd_b(upd_b), .sync_ok_b(sync_ok_b),
    .pref_b(pref_b), .force_en(force_en), .force_sel(force_sel),
    .ntp_time(ntp_time), .ntp_time_upd(ntp_time_upd), .active_src(active_src),
    .valid(valid), .switch_count(switch_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  longint      cyc = 0;
  longint      last_a, last_b;   // cycle index of each source's latest strobe
  int          m_st;             // 0 none, 1 on A, 2 on B
  int          m_streak;         // consecutive cycles the preferred source stayed healthy while parked
  int          m_sw, m_drop;
  logic [63:0] m_last;
  bit          m_upd;
  logic [63:0] ta, tbv;

  function automatic logic [98:0] dut_vec();
    return {ntp_time, ntp_time_upd, valid, active_src, switch_count, drop_count};
  endfunction

  function automatic logic [98:0] exp_vec();
    return {m_last, m_upd, (m_st != 0), (m_st == 2), 16'(m_sw), 16'(m_drop)};
  endfunction

  function automatic logic [63:0] junk();
    return {$urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    m_st = 0; m_streak = 0; m_sw = 0; m_drop = 0; m_last = '0; m_upd = 1'b0;
    last_a = -1000000; last_b = -1000000;
  endtask

  // Advance one clock; the model applies the rules to the inputs sampled at this edge.
  task automatic step();
    bit ha, hb, pref_ok, other_ok, act_ok, alt_ok, fwd;
    int pref_id, nx, sn;
    logic [63:0] t;
    ha = sync_ok_a && ((cyc - last_a) <= TO);
    hb = sync_ok_b && ((cyc - last_b) <= TO);
    pref_id  = pref_b ? 2 : 1;
    pref_ok  = pref_b ? hb : ha;
    other_ok = pref_b ? ha : hb;
    act_ok   = (m_st == 1) ? ha : hb;
    alt_ok   = (m_st == 1) ? hb : ha;
    nx = m_st;
    sn = 0;
    if (force_en)              nx = force_sel ? (hb ? 2 : 0) : (ha ? 1 : 0);
    else if (m_st == 0)        nx = pref_ok ? pref_id : (other_ok ? 3 - pref_id : 0);
    else if (!act_ok)          nx = alt_ok ? 3 - m_st : 0;
    else if (m_st != pref_id && pref_ok) begin
      sn = m_streak + 1;
      if (sn >= HO) nx = pref_id;
    end
    if (nx != m_st) sn = 0;
    fwd = (m_st == 1 && upd_a) || (m_st == 2 && upd_b);
    t   = (m_st == 2) ? time_b : time_a;
    m_upd = 1'b0;
    if (fwd) begin
      if (t >= m_last) begin m_last = t; m_upd = 1'b1; end
      else if (m_drop < 65535) m_drop++;
    end
    if (m_st != 0 && nx != 0 && nx != m_st && m_sw < 65535) m_sw++;
    m_st = nx;
    m_streak = sn;
    if (upd_a) last_a = cyc;
    if (upd_b) last_b = cyc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    {upd_a, upd_b, sync_ok_a, sync_ok_b, pref_b, force_en, force_sel} = '0;
    time_a = '0; time_b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (dut_vec() !== 99'd0) begin
      n_bad++; $display("FAIL reset_state got=%h want=%h", dut_vec(), 99'd0);
    end
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL reset_idle cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single_source();
    sync_ok_a = 1'b1; pref_b = 1'b0;
    ta = 64'h0000_0001_0000_0000;
    for (int k = 0; k < 60; k++) begin
      upd_a  = (k % 10 == 0);
      time_a = upd_a ? ta : junk();
      time_b = junk();
      step();
      if (upd_a) ta += 64'h100;
      upd_a = 1'b0;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL single_src cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_failover();
    sync_ok_b = 1'b1;
    tbv = ta + 64'h1_0000;
    for (int k = 0; k < 100; k++) begin
      upd_a  = (k < 60) && (k % 10 == 0);
      upd_b  = (k % 7 == 0);
      time_a = upd_a ? ta : junk();
      time_b = upd_b ? tbv : junk();
      step();
      if (upd_a) ta  += 64'h100;
      if (upd_b) tbv += 64'h100;
      {upd_a, upd_b} = 2'b00;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL failover cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_revert();
    ta = tbv + 64'h10_0000;
    for (int k = 0; k < 160; k++) begin
      upd_a     = (k % 10 == 0);
      upd_b     = (k % 7 == 0);
      sync_ok_a = (k != 31);
      time_a    = upd_a ? ta : junk();
      time_b    = upd_b ? tbv : junk();
      step();
      if (upd_a) ta  += 64'h100;
      if (upd_b) tbv += 64'h100;
      {upd_a, upd_b} = 2'b00;
      sync_ok_a = 1'b1;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL revert cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_monotonic();
    logic [63:0] base;
    base = {ta[63:16] + 48'd1, 16'h0000};
    tbv  = base + 64'h500;
    for (int k = 0; k < 120; k++) begin
      upd_a  = (k == 0);
      upd_b  = (k % 4 == 0);
      time_a = upd_a ? base + 64'h600 : junk();
      time_b = upd_b ? tbv : junk();
      step();
      if (upd_b) tbv += 64'h10;
      {upd_a, upd_b} = 2'b00;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL monotonic cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_force();
    ta = tbv + 64'h10_0000;
    force_sel = 1'b1;
    for (int k = 0; k < 170; k++) begin
      force_en  = (k < 140);
      sync_ok_b = !(k >= 130 && k < 140);
      upd_a     = (k % 10 == 0);
      upd_b     = (k % 6 == 0);
      time_a    = upd_a ? ta : junk();
      time_b    = upd_b ? tbv : junk();
      step();
      if (upd_a) ta  += 64'h100;
      if (upd_b) tbv += 64'h100;
      {upd_a, upd_b} = 2'b00;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL force cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
      end
    end
    force_en = 1'b0; sync_ok_b = 1'b1;
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 20; k++) begin
      upd_a  = (k % 5 == 0);
      time_a = upd_a ? ta : junk();
      step();
      if (upd_a) ta += 64'h100;
      upd_a = 1'b0;
    end
    upd_a = 1'b1; time_a = ta;
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (dut_vec() !== 99'd0) begin
      n_bad++; $display("FAIL async_reset_now got=%h want=%h", dut_vec(), 99'd0);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (dut_vec() !== 99'd0) begin
      n_bad++; $display("FAIL async_reset_held got=%h want=%h", dut_vec(), 99'd0);
    end
    upd_a = 1'b0;
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 40; k++) begin
      upd_a  = (k >= 15) && (k % 5 == 0);
      upd_b  = 1'b0;
      time_a = upd_a ? ta : junk();
      time_b = junk();
      step();
      if (upd_a) ta += 64'h100;
      upd_a = 1'b0;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL post_reset cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int rate_a, rate_b;
    rate_a = 20; rate_b = 20;
    tbv = ta;
    for (int k = 0; k < 3000; k++) begin
      if (k % 400 == 0) begin
        rate_a = (k % 800 == 0) ? 5 : 100;
        rate_b = $urandom_range(0, 3) * 30;
      end
      if ($urandom_range(0, 199) == 0) pref_b    = ~pref_b;
      if ($urandom_range(0, 59)  == 0) sync_ok_a = ~sync_ok_a;
      if ($urandom_range(0, 59)  == 0) sync_ok_b = ~sync_ok_b;
      if ($urandom_range(0, 299) == 0) force_en  = ~force_en;
      if ($urandom_range(0, 99)  == 0) force_sel = ~force_sel;
      upd_a = ($urandom_range(0, 99) < rate_a);
      upd_b = ($urandom_range(0, 99) < rate_b);
      if (upd_a) ta  = ta  + 64'($urandom_range(0, 768)) - (($urandom_range(0, 9) == 0) ? 64'h400 : 64'h0);
      if (upd_b) tbv = tbv + 64'($urandom_range(0, 768)) - (($urandom_range(0, 9) == 0) ? 64'h400 : 64'h0);
      time_a = upd_a ? ta  : junk();
      time_b = upd_b ? tbv : junk();
      step();
      {upd_a, upd_b} = 2'b00;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_failover();
    test_revert();
    test_monotonic();
    test_force();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
